// File: rtl/nap_rd_arb_pkg.sv
// Shared types and sizing helpers for the NAP AXI read arbiter.
// Imported by the arbiter top and its round-robin core.
package nap_rd_arb_pkg;

  typedef enum logic [0:0] {
    AR_IDLE,
    AR_ISSUE
  } t_ar_state;

  localparam int DEF_MAX_OUTSTANDING = 16;
  localparam int DEF_CNT_W = $clog2(DEF_MAX_OUTSTANDING + 1);

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/nap_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after the last grant.
// Shared between the read and write NAP arbiters.
module nap_rr_arbiter
  import nap_rd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any_grant
);

  // Upper pass covers requesters above the pointer, then wrap to the rest.
  always_comb begin
    gnt       = '0;
    idx       = '0;
    any_grant = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!any_grant && req[r] && (r > int'(last))) begin
        any_grant = 1'b1;
        gnt[r]    = 1'b1;
        idx       = IDX_W'(r);
      end
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      if (!any_grant && req[r] && (r <= int'(last))) begin
        any_grant = 1'b1;
        gnt[r]    = 1'b1;
        idx       = IDX_W'(r);
      end
    end
  end

endmodule

// File: rtl/nap_axi_rd_arbiter.sv
// Shares one NAP AXI read port (AR/R) between NUM_REQ requesters.
// Round-robin AR issue with per-requester burst limits; R routed by RID.
module nap_axi_rd_arbiter
  import nap_rd_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 42,
  parameter int DATA_WIDTH      = 256,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 16,
  localparam int IDX_W = idx_width(NUM_REQ),
  localparam int RID_W = ID_WIDTH - IDX_W
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_REQ-1:0]            i_req_arvalid,
  output logic [NUM_REQ-1:0]            o_req_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_araddr,
  input  logic [NUM_REQ*8-1:0]          i_req_arlen,
  input  logic [NUM_REQ*3-1:0]          i_req_arsize,
  input  logic [NUM_REQ*2-1:0]          i_req_arburst,
  input  logic [NUM_REQ*RID_W-1:0]      i_req_arid,
  output logic [NUM_REQ-1:0]            o_req_rvalid,
  input  logic [NUM_REQ-1:0]            i_req_rready,
  output logic [DATA_WIDTH-1:0]         o_req_rdata,
  output logic [RID_W-1:0]              o_req_rid,
  output logic [1:0]                    o_req_rresp,
  output logic                          o_req_rlast,
  output logic                          o_nap_arvalid,
  input  logic                          i_nap_arready,
  output logic [ADDR_WIDTH-1:0]         o_nap_araddr,
  output logic [7:0]                    o_nap_arlen,
  output logic [2:0]                    o_nap_arsize,
  output logic [1:0]                    o_nap_arburst,
  output logic [ID_WIDTH-1:0]           o_nap_arid,
  input  logic                          i_nap_rvalid,
  output logic                          o_nap_rready,
  input  logic [DATA_WIDTH-1:0]         i_nap_rdata,
  input  logic [ID_WIDTH-1:0]           i_nap_rid,
  input  logic [1:0]                    i_nap_rresp,
  input  logic                          i_nap_rlast,
  output logic                          o_err_bad_id,
  output logic                          o_err_underflow
);

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDX_W:0]   NREQ    = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

  t_ar_state state, state_n;

  logic [IDX_W-1:0]      ptr;
  logic [CNT_W-1:0]      cnt [NUM_REQ];
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    zero;
  logic [NUM_REQ-1:0]    rr_gnt;
  logic [NUM_REQ-1:0]    take;
  logic [NUM_REQ-1:0]    sel;
  logic [NUM_REQ-1:0]    dec;
  logic [IDX_W-1:0]      rr_idx;
  logic [IDX_W-1:0]      r_idx;
  logic                  rr_any;
  logic                  can_take;
  logic                  r_ok;
  logic                  r_hs;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_len;
  logic [2:0]            sel_size;
  logic [1:0]            sel_burst;
  logic [RID_W-1:0]      sel_id;

  always_comb begin
    elig = '0;
    zero = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      elig[r] = i_req_arvalid[r] && (cnt[r] < CNT_MAX);
      zero[r] = (cnt[r] == '0);
    end
  end

  nap_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req       (elig),
    .last      (ptr),
    .gnt       (rr_gnt),
    .idx       (rr_idx),
    .any_grant (rr_any)
  );

  // A new AR can be taken while idle or when the held one drains.
  assign can_take = (state == AR_IDLE) || i_nap_arready;
  assign take = (can_take && rr_any && !i_reset) ? rr_gnt : '0;
  assign o_req_arready = take;
  assign o_nap_arvalid = (state == AR_ISSUE);

  always_comb begin
    state_n = state;
    unique case (state)
      AR_IDLE:  if (rr_any) state_n = AR_ISSUE;
      AR_ISSUE: if (i_nap_arready && !rr_any) state_n = AR_IDLE;
      default:  state_n = AR_IDLE;
    endcase
  end

  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    sel_id    = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (rr_gnt[r]) begin
        sel_addr  = i_req_araddr[r*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len   = i_req_arlen[r*8 +: 8];
        sel_size  = i_req_arsize[r*3 +: 3];
        sel_burst = i_req_arburst[r*2 +: 2];
        sel_id    = i_req_arid[r*RID_W +: RID_W];
      end
    end
  end

  always_comb begin
    r_idx = i_nap_rid[ID_WIDTH-1 -: IDX_W];
    r_ok  = ({1'b0, r_idx} < NREQ);
    sel   = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      sel[r] = r_ok && (r_idx == IDX_W'(r));
    end
  end

  // Beats with an unknown index are swallowed so the NAP never stalls.
  assign o_req_rvalid = sel & {NUM_REQ{i_nap_rvalid}};
  assign o_nap_rready = r_ok ? |(i_req_rready & sel) : 1'b1;
  assign r_hs = i_nap_rvalid && o_nap_rready;
  assign dec = sel & {NUM_REQ{r_hs && i_nap_rlast}};

  assign o_req_rdata = i_nap_rdata;
  assign o_req_rid   = i_nap_rid[RID_W-1:0];
  assign o_req_rresp = i_nap_rresp;
  assign o_req_rlast = i_nap_rlast;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= AR_IDLE;
      ptr             <= PTR_RST;
      o_nap_araddr    <= '0;
      o_nap_arlen     <= '0;
      o_nap_arsize    <= '0;
      o_nap_arburst   <= '0;
      o_nap_arid      <= '0;
      o_err_bad_id    <= 1'b0;
      o_err_underflow <= 1'b0;
    end else begin
      state <= state_n;
      if (|take) begin
        ptr           <= rr_idx;
        o_nap_araddr  <= sel_addr;
        o_nap_arlen   <= sel_len;
        o_nap_arsize  <= sel_size;
        o_nap_arburst <= sel_burst;
        o_nap_arid    <= {rr_idx, sel_id};
      end
      o_err_bad_id    <= i_nap_rvalid && !r_ok;
      o_err_underflow <= |(dec & zero);
    end
  end

  always_ff @(posedge i_clk) begin
    for (int r = 0; r < NUM_REQ; r++) begin
      if (i_reset) begin
        cnt[r] <= '0;
      end else if (take[r] && !dec[r]) begin
        cnt[r] <= cnt[r] + 1'b1;
      end else if (dec[r] && !take[r] && !zero[r]) begin
        cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

endmodule

// File: doc/nap_axi_rd_arbiter.md
Name: nap_axi_rd_arbiter

Overview:
- Shares the AXI read channels (AR/R) of one ACX_NAP_AXI_SLAVE between NUM_REQ user-logic requesters.
- AR requests are granted round-robin, registered, and issued to the NAP. The requester index is prepended to ARID.
- R beats are routed back combinationally by the index field of RID.
- A per-requester outstanding-burst limit stops any requester from monopolising NoC read credits.
- Sits between the user read engines and the NAP slave wrapper's AR/R signals.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 42, NAP AXI address width.
- DATA_WIDTH, 256, NAP AXI data width.
- ID_WIDTH, 8, NAP AXI ID width.
- MAX_OUTSTANDING, 16, maximum in-flight read bursts per requester (1..255).
- IDX_W (derived), $clog2(NUM_REQ), requester index width; occupies ARID/RID[ID_WIDTH-1 -: IDX_W].
- RID_W (derived), ID_WIDTH-IDX_W, requester-visible ID width.

Ports:
- i_clk  in  1  clock, shared with NAP.
- i_reset  in  1  synchronous, active-high reset.
- i_req_arvalid  in  NUM_REQ  per-requester AR valid.
- o_req_arready  out  NUM_REQ  per-requester AR ready; one-hot or zero.
- i_req_araddr  in  NUM_REQ*ADDR_WIDTH  packed; requester r at [r*ADDR_WIDTH +: ADDR_WIDTH].
- i_req_arlen  in  NUM_REQ*8  packed burst lengths.
- i_req_arsize  in  NUM_REQ*3  packed.
- i_req_arburst  in  NUM_REQ*2  packed.
- i_req_arid  in  NUM_REQ*RID_W  packed.
- o_req_rvalid  out  NUM_REQ  per-requester R valid; one-hot or zero.
- i_req_rready  in  NUM_REQ  per-requester R ready.
- o_req_rdata  out  DATA_WIDTH  broadcast.
- o_req_rid  out  RID_W  broadcast; i_nap_rid low bits.
- o_req_rresp  out  2  broadcast.
- o_req_rlast  out  1  broadcast.
- o_nap_arvalid  out  1  to NAP.
- i_nap_arready  in  1  from NAP.
- o_nap_araddr  out  ADDR_WIDTH  to NAP.
- o_nap_arlen  out  8  to NAP.
- o_nap_arsize  out  3  to NAP.
- o_nap_arburst  out  2  to NAP.
- o_nap_arid  out  ID_WIDTH  {grant index, requester ID}.
- i_nap_rvalid  in  1  from NAP.
- o_nap_rready  out  1  to NAP.
- i_nap_rdata  in  DATA_WIDTH  from NAP.
- i_nap_rid  in  ID_WIDTH  from NAP.
- i_nap_rresp  in  2  from NAP.
- i_nap_rlast  in  1  from NAP.
- o_err_bad_id  out  1  registered pulse: RID index >= NUM_REQ.
- o_err_underflow  out  1  registered pulse: rlast for a requester whose count is 0.

Behaviour:
- Reset values:
  - o_nap_arvalid=0, all AR payload registers 0, o_req_arready=0.
  - All outstanding counters 0; error outputs 0.
  - RR last-grant pointer = NUM_REQ-1, so requester 0 has first priority.
- Eligibility: eligible[r] = i_req_arvalid[r] && cnt[r] < MAX_OUTSTANDING.
- AR state machine, states IDLE and ISSUE:
  - IDLE: if any requester is eligible, grant g = first eligible after the pointer (round-robin). In the same cycle: o_req_arready[g]=1 (combinational), payload captured into registers, pointer<=g, cnt[g]++. Next state ISSUE.
  - ISSUE: o_nap_arvalid=1; payload held stable until i_nap_arready.
  - ISSUE with i_nap_arready and an eligible requester: grant in the same cycle, reload registers, stay ISSUE. This gives back-to-back issue at one AR per cycle.
  - ISSUE with i_nap_arready and no eligible requester: go to IDLE.
  - ISSUE without i_nap_arready: o_req_arready=0.
- AR latency: grant cycle +1 to o_nap_arvalid.
- R path, zero-latency combinational; idx = i_nap_rid[ID_WIDTH-1 -: IDX_W]:
  - Valid idx: o_req_rvalid[idx]=i_nap_rvalid; o_nap_rready=i_req_rready[idx]; no other rvalid asserted.
  - Invalid idx (>= NUM_REQ): o_nap_rready=1 so the beat is dropped; o_err_bad_id pulses on the next cycle.
- Counters:
  - Decrement cnt[idx] on an R handshake with i_nap_rlast=1.
  - Increment and decrement of the same counter in the same cycle: counter unchanged.
  - Decrement at 0: counter stays 0, o_err_underflow pulses.
- Reset mid-operation:
  - The pending AR is discarded and counters are cleared.
  - The NAP must be held in reset concurrently; responses to discarded bursts are undefined.
- rresp is passed through unmodified. The block never reorders beats.

Decomposition:
- Package nap_rd_arb_pkg:
  - state enum t_ar_state {AR_IDLE, AR_ISSUE}.
  - Function idx_width(n).
  - Localparam for counter width $clog2(MAX_OUTSTANDING+1).
- Sub-module nap_rr_arbiter (NUM_REQ): inputs request vector and last pointer; output one-hot grant, binary index and any_grant. Purely combinational round-robin, reused by future write arbiter.

Test Plan:
- Single requester 1, arid=5, arlen=3, nap arready=1 → o_nap_arid=8'h45, arvalid the cycle after arready[1]. Four R beats with rid=8'h45 → only o_req_rvalid[1], o_req_rid=5; cnt[1] returns to 0.
- All 4 requesters held valid, nap arready=1 → grants 0,1,2,3,0 on consecutive cycles, one AR per cycle.
- MAX_OUTSTANDING=2: requester 2 issues 2 ARs with no R → third request is not granted. One rlast to requester 2 → granted on the next cycle.
- i_nap_arready low for 5 cycles → araddr/arid stable, no o_req_arready asserted, then resumes.
- With NUM_REQ=3, rid index 3 → o_nap_rready=1, no o_req_rvalid, o_err_bad_id=1 for one cycle. Separately, rlast to requester 0 with count 0 → o_err_underflow pulse, cnt[0] stays 0.
- i_reset asserted during ISSUE → o_nap_arvalid=0 and counters 0 on the next cycle; grant order restarts at requester 0.
